// File: rtl/contador_param_pkg.sv
// Shared FSM state encoding and the pop-count helper used by contador_param.
package contador_param_pkg;

  typedef enum logic {
    S_COUNT = 1'b0,
    S_RESP  = 1'b1
  } state_t;

  localparam int unsigned POP_MAX_W = 32;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/contador_canal.sv
// One pop counter with a sticky overflow flag, plus wrap or saturate behaviour.
module contador_canal
  import contador_param_pkg::*;
#(
  parameter int unsigned CNT_W = 5,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr_i,
  input  logic             rd_clr,
  input  logic             rd_inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rd_clr) begin
      // A clearing read restarts the count with this edge's pop.
      cnt_d    = '0;
      cnt_d[0] = rd_inc;
      ovf_d    = 1'b0;
    end else if (inc) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        if (!SAT) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/contador_param.sv
// Per-channel pop counters with a running total, read out over a req/valid
// handshake that is only accepted while the system is idle.
module contador_param
  import contador_param_pkg::*;
#(
  parameter int unsigned FIFO_UNITS  = 4,
  parameter int unsigned INDEX       = 2,
  parameter int unsigned CNT_W       = 5,
  parameter bit          SAT         = 1'b0,
  parameter bit          CLR_ON_READ = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FIFO_UNITS-1:0]  pop,
  input  logic                   IDLE,
  input  logic                   req,
  input  logic [INDEX-1:0]       idx,
  input  logic                   clr,
  output logic [CNT_W-1:0]       cuenta,
  output logic [CNT_W+INDEX-1:0] contador_total,
  output logic                   valid,
  output logic [FIFO_UNITS-1:0]  ovf
);

  localparam int unsigned TOT_W = CNT_W + INDEX;

  state_t           state_q, state_d;
  logic             accept;
  logic [CNT_W-1:0] cnt_w [FIFO_UNITS];
  logic [FIFO_UNITS-1:0] rd_clr_w;
  logic [CNT_W-1:0] sel_cnt;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W:0]   tot_sum;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic [TOT_W-1:0] total_q, total_d;

  assign accept = req & IDLE;

  for (genvar g = 0; g < FIFO_UNITS; g++) begin : g_canal
    contador_canal #(
      .CNT_W(CNT_W),
      .SAT  (SAT)
    ) u_canal (
      .clk   (clk),
      .reset (reset),
      .inc   (pop[g]),
      .clr_i (clr),
      .rd_clr(rd_clr_w[g]),
      .rd_inc(pop[g]),
      .cnt   (cnt_w[g]),
      .ovf   (ovf[g])
    );
  end

  // Out-of-range idx matches no channel, so it reads back as zero.
  always_comb begin
    sel_cnt  = '0;
    rd_clr_w = '0;
    for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
      if (idx == INDEX'(i)) begin
        sel_cnt     = cnt_w[i];
        rd_clr_w[i] = CLR_ON_READ & accept;
      end
    end
  end

  always_comb begin
    tot_sum = {1'b0, tot_q} + (TOT_W+1)'(popcount(POP_MAX_W'(pop)));
    tot_d   = tot_sum[TOT_W-1:0];
    if (clr)                        tot_d = '0;
    else if (SAT && tot_sum[TOT_W]) tot_d = '1;
  end

  always_comb begin
    state_d  = S_COUNT;
    cuenta_d = cuenta_q;
    total_d  = total_q;
    if (accept) begin
      state_d  = S_RESP;
      cuenta_d = sel_cnt;
      total_d  = tot_q;
    end
    valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_COUNT;
      tot_q    <= '0;
      cuenta_q <= '0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      tot_q    <= tot_d;
      cuenta_q <= cuenta_d;
      total_q  <= total_d;
    end
  end

  assign cuenta         = cuenta_q;
  assign contador_total = total_q;

endmodule
